uart_rx_buffer: RTL
===================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 2: clk cycles per serial bit; legal values are >= 2.
REQ-003 SHALL have parameter DEPTH, default 4: receive FIFO entries; must be a power of two, >= 2.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port uart_rx_line, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port rx_data, output, WIDTH bits: FIFO head byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: the FIFO is non-empty and rx_data is valid.
REQ-009 SHALL have port rx_ready, input, 1 bit: consumer accepts the head byte when rx_valid and rx_ready are both 1.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse marking a byte dropped because the FIFO was full.
REQ-012 SHALL have port busy, output, 1 bit: the receiver FSM is not in IDLE.

Function
REQ-013 SHALL pass uart_rx_line through a 2-flop synchronizer, reset to 1; all FSM decisions use the synchronized value only.
REQ-014 SHALL use frame format: start bit 0, then WIDTH data bits LSB first, then stop bit 1; there is no parity bit.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-timer and a bit-index counter sized $clog2 of the respective maxima.
REQ-016 IDLE -> START on the first synchronized low sample; bit-timer loads CLKS_PER_BIT/2 (integer division).
REQ-017 START: on bit-timer expiry (mid-bit), sample 0 -> DATA with timer loaded to CLKS_PER_BIT; sample 1 is a glitch -> IDLE, with no flag and no write.
REQ-018 DATA: each expiry samples the line into shift bit [index], index increments, timer reloads CLKS_PER_BIT; after bit WIDTH-1 -> STOP.
REQ-019 STOP: on expiry, sample 1 -> push byte to FIFO, then IDLE; sample 0 -> frame_err pulse, byte discarded, then go to IDLE, but stay there until the line is seen high before re-arming start detection.
REQ-020 A byte SHALL appear on rx_valid/rx_data the clk cycle after the stop-bit mid-sample edge.
REQ-021 A push while the FIFO is full SHALL drop the new byte, pulse overrun, and leave FIFO contents unchanged.
REQ-022 A push and a pop in the same cycle SHALL both take effect; when full, a simultaneous pop frees space so the push succeeds with no overrun.
REQ-023 FIFO pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; full when the MSBs differ and the rest are equal; empty when the pointers are equal.
REQ-024 rx_data SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-025 busy SHALL be 0 in IDLE and 1 otherwise, including during the post-error wait for the line to go high.

Reset
REQ-026 On rst_n=0, immediately and asynchronously: FSM = IDLE, counters = 0, synchronizer = 1, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, the receiver re-arms only on a fresh falling edge.

Structure
REQ-028 FSM state encoding and frame constants (start=0, stop=1) SHALL live in the shared package bbcpu_uart_pkg, reused by the transmitter.
REQ-029 The FIFO SHALL be a separate sub-module uart_rx_fifo with parameters WIDTH and DEPTH and ports push, pop, full, empty.
REQ-030 The top-level RTL SHALL contain only the synchronizer, the FSM, and flag generation.

Verification
REQ-031 Send frames 0x01,0x01,0x02,0x03,0x05,0x08 back-to-back at CLKS_PER_BIT=2 with rx_ready=1 -> six rx_valid pulses in that order, no flags.
REQ-032 Drive a 1-clk low glitch on an idle line -> busy returns to 0 within 2 cycles, no rx_valid, no frame_err.
REQ-033 Send 0xA5 with stop bit 0 -> frame_err pulses once, FIFO stays empty; a following 0x3C is received correctly.
REQ-034 DEPTH=4, rx_ready=0, send 0x10..0x14 -> FIFO holds 0x10..0x13, one overrun pulse on the fifth byte; drain then yields 0x10,0x11,0x12,0x13.
REQ-035 With FIFO full, assert rx_ready in the stop-sample cycle of the fifth byte -> 0x10 popped, 0x14 stored, no overrun.
REQ-036 Assert rst_n=0 after data bit 3 of 0xFF -> outputs reach reset values immediately, no byte is delivered; the next frame 0x55 is received correctly.

Source files
------------

// File: rtl/bbcpu_uart_pkg.sv
// rtl/bbcpu_uart_pkg.sv - shared UART state encoding and frame constants
package bbcpu_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with wrap-bit pointers
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head byte reads as zero while empty so the output is defined after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty gates the read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receiver with line synchronizer and receive FIFO
module uart_rx_buffer
  import bbcpu_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int DEPTH        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx_line,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  uart_state_e      state;
  logic [TW-1:0]    bit_timer;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shift_reg;
  logic             wait_high;
  logic             sync_q1;
  logic             line_sync;
  logic             timer_done;
  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rx_pop;

  assign timer_done = (bit_timer == TW'(1));
  assign push_req   = (state == ST_STOP) && timer_done && (line_sync == STOP_BIT);
  assign rx_valid   = !fifo_empty;
  assign rx_pop     = rx_valid && rx_ready;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      sync_q1   <= uart_rx_line;
      line_sync <= sync_q1;
    end
  end

  // Receive FSM: mid-bit sampling, frame checking and busy/frame_err generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      wait_high <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wait_high) begin
            if (line_sync == STOP_BIT) begin
              wait_high <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (line_sync == START_BIT) begin
            state     <= ST_START;
            bit_timer <= HALF_BIT;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          if (timer_done) begin
            if (line_sync == START_BIT) begin
              state     <= ST_DATA;
              bit_timer <= FULL_BIT;
              bit_idx   <= '0;
            end else begin
              state     <= ST_IDLE;
              bit_timer <= '0;
              busy      <= 1'b0;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        ST_DATA: begin
          if (timer_done) begin
            shift_reg[bit_idx] <= line_sync;
            bit_timer          <= FULL_BIT;
            if (bit_idx == LAST_IDX) begin
              state   <= ST_STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        ST_STOP: begin
          if (timer_done) begin
            state     <= ST_IDLE;
            bit_timer <= '0;
            if (line_sync == STOP_BIT) begin
              busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          bit_timer <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Overrun pulses only when the byte is really dropped (no pop freeing space).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && fifo_full && !rx_pop;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
